// File: rtl/inport_assembler.sv
// inport_assembler: packs header beats into a PHV, drops bytes beyond PHV_BYTES, holds the PHV until downstream takes it
module inport_assembler #(
    parameter int BEAT_BYTES = 32,
    parameter int PHV_BYTES  = 128,
    localparam int BEATS     = PHV_BYTES / BEAT_BYTES,
    localparam int LW        = $clog2(PHV_BYTES + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [BEAT_BYTES*8-1:0] io_in_data,
    input  logic                    io_in_last,
    output logic [PHV_BYTES*8-1:0]  io_phv_out_data,
    output logic                    io_phv_out_valid,
    input  logic                    io_phv_out_ready,
    output logic [LW-1:0]           io_phv_out_len,
    output logic                    io_phv_out_trunc,
    output logic [31:0]             io_pkt_count
);
    localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int PW = PHV_BYTES * 8;

    typedef enum logic [1:0] {COLLECT, DISCARD, HOLD} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [PW-1:0]   phv, beat_pos, beat_mask;
    logic [LW-1:0]   len;
    logic            trunc;
    logic [31:0]     pkt_count;
    logic            accept, handoff, final_beat;
    int              shift;

    always_comb begin
        io_in_ready      = !reset && state != HOLD;
        io_phv_out_valid = state == HOLD;
        accept           = io_in_valid && io_in_ready;
        handoff          = io_phv_out_valid && io_phv_out_ready;
        final_beat       = idx == IW'(BEATS - 1);
        shift            = (BEATS - 1 - int'(idx)) * BEAT_BYTES * 8;
        beat_pos         = PW'(io_in_data) << shift;
        beat_mask        = PW'({BEAT_BYTES*8{1'b1}}) << shift;
        state_n          = state;
        idx_n            = idx;
        case (state)
            COLLECT: if (accept) begin
                state_n = io_in_last ? HOLD : final_beat ? DISCARD : COLLECT;
                idx_n   = (io_in_last || final_beat) ? '0 : idx + 1'b1;
            end
            DISCARD: state_n = (accept && io_in_last) ? HOLD : DISCARD;
            HOLD:    state_n = handoff ? COLLECT : HOLD;
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= COLLECT;
            idx       <= '0;
            phv       <= '0;
            len       <= '0;
            trunc     <= 1'b0;
            pkt_count <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state == COLLECT && accept) begin
                // the first beat wipes the whole PHV so bytes past len read as zero
                phv <= idx == '0 ? beat_pos : (phv & ~beat_mask) | beat_pos;
                if (io_in_last) begin
                    len   <= LW'((int'(idx) + 1) * BEAT_BYTES);
                    trunc <= 1'b0;
                end else if (final_beat) begin
                    len   <= LW'(PHV_BYTES);
                    trunc <= 1'b1;
                end
            end
            if (handoff) pkt_count <= pkt_count + 1'b1;
        end
    end

    assign io_phv_out_data  = phv;
    assign io_phv_out_len   = len;
    assign io_phv_out_trunc = trunc;
    assign io_pkt_count     = pkt_count;
endmodule

// File: doc/inport_assembler.md
INPORT_ASSEMBLER -- requirements
Module: inport_assembler

Interface
REQ-001 The block SHALL have parameter BEAT_BYTES, default 32, giving the width in bytes of one input beat.
REQ-002 The block SHALL have parameter PHV_BYTES, default 128, giving the PHV size in bytes; it SHALL be a multiple of BEAT_BYTES.
REQ-003 The block SHALL derive BEATS = PHV_BYTES/BEAT_BYTES (default 4) and LW = clog2(PHV_BYTES+1) (default 8).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port io_in_valid, input, 1 bit: the beat on io_in_data is valid.
REQ-007 The block SHALL have port io_in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port io_in_data, input, BEAT_BYTES*8 bits: header beat; beat byte 0 is bits [BEAT_BYTES*8-1 -: 8].
REQ-009 The block SHALL have port io_in_last, input, 1 bit: the current beat is the final beat of the packet header.
REQ-010 The block SHALL have port io_phv_out_data, output, PHV_BYTES*8 bits: assembled PHV; PHV byte 0 is the MSB byte.
REQ-011 The block SHALL have port io_phv_out_valid, output, 1 bit: the PHV is valid.
REQ-012 The block SHALL have port io_phv_out_ready, input, 1 bit: the downstream accepts the PHV.
REQ-013 The block SHALL have port io_phv_out_len, output, LW bits: the number of PHV bytes filled from input.
REQ-014 The block SHALL have port io_phv_out_trunc, output, 1 bit: the packet carried more than PHV_BYTES bytes and the excess was dropped.
REQ-015 The block SHALL have port io_pkt_count, output, 32 bits: count of PHVs handed off, wrapping modulo 2^32.

Function
REQ-016 The block SHALL count a beat as accepted when io_in_valid && io_in_ready, and a PHV as handed off when io_phv_out_valid && io_phv_out_ready.
REQ-017 The block SHALL implement exactly three states: COLLECT, DISCARD and HOLD.
REQ-018 In COLLECT and DISCARD the block SHALL drive io_in_ready=1 and io_phv_out_valid=0; in HOLD it SHALL drive io_in_ready=0 and io_phv_out_valid=1.
REQ-019 In COLLECT, an accepted beat SHALL be written to PHV bytes [idx*BEAT_BYTES .. idx*BEAT_BYTES+BEAT_BYTES-1] in beat-byte order, where idx is a beat index counting 0..BEATS-1.
REQ-020 When the accepted beat has idx=0, all other PHV bytes SHALL be cleared to 0 in the same cycle, so bytes at or beyond len always read 0.
REQ-021 In COLLECT, an accepted beat with io_in_last=1 SHALL set len=(idx+1)*BEAT_BYTES, set trunc=0, reset idx to 0 and move the block to HOLD.
REQ-022 In COLLECT, an accepted beat with idx=BEATS-1 and io_in_last=0 SHALL set len=PHV_BYTES, set trunc=1, reset idx to 0 and move the block to DISCARD.
REQ-023 Otherwise, an accepted beat in COLLECT SHALL increment idx.
REQ-024 In DISCARD, accepted beats SHALL be dropped without changing the PHV; the block SHALL move to HOLD on the beat with io_in_last=1.
REQ-025 io_phv_out_valid SHALL rise on the cycle after the last beat is accepted (latency 1).
REQ-026 In HOLD, io_phv_out_data, io_phv_out_len and io_phv_out_trunc SHALL be stable until hand-off.
REQ-027 On hand-off the block SHALL return to COLLECT and increment io_pkt_count, with 0xFFFFFFFF wrapping to 0.
REQ-028 The block SHALL give a sustained throughput of one PHV per (beats received + 1) cycles when io_phv_out_ready=1.
REQ-029 In any state, io_in_data SHALL be ignored when io_in_valid=0; no state change occurs without a handshake.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL enter COLLECT with idx=0, PHV=0, len=0, trunc=0, io_pkt_count=0, io_phv_out_valid=0 and io_in_ready=0.
REQ-031 io_in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-032 Reset asserted mid-packet or in HOLD SHALL discard the partial or pending PHV without incrementing the count.

Verification
REQ-033 4 beats of 0x00..0x7F in byte order (last on beat 4), out_ready=1 -> next cycle out_valid=1, byte k = k, len=128, trunc=0, count=1.
REQ-034 2-beat packet of 0xAA bytes after a full packet -> bytes 0..63 = 0xAA, bytes 64..127 = 0, len=64, trunc=0.
REQ-035 6-beat packet (last on beat 6) -> beats 1-4 in PHV, beats 5-6 dropped with in_ready=1, len=128, trunc=1.
REQ-036 out_ready held 0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, count unchanged; release -> one hand-off, count +1.
REQ-037 Reset pulsed after beat 2 of 4 -> out_valid stays 0 and count=0; next full packet assembles correctly.
REQ-038 Count forced near wrap (0xFFFFFFFF) plus one hand-off -> io_pkt_count=0.
